// File: rtl/stencil_read_streamer.sv
// Stencil-to-host read streamer: buffers stencil result words in a small FIFO and
// presents them as one FRAME_LEN-word frame per host open. Optional STREAM_ERRCNT_EN adds err_cnt.
module stencil_read_streamer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned FRAME_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_out_wr_en,
    input  logic [31:0] io_out_data,
    output logic        io_out_full,
    input  logic        user_r_rden,
    output logic        user_r_empty,
    output logic [31:0] user_r_data,
    output logic        user_r_eof,
    input  logic        user_r_open
`ifdef STREAM_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]          FRAME_END  = 16'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [15:0]           words_read;

    logic                  full_int;
    logic                  empty_int;
    logic                  eof_int;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        full_int   = 1'b1;
        empty_int  = 1'b1;
        eof_int    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (user_r_open) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                full_int  = (level == LEVEL_FULL);
                empty_int = !((level != '0) && (words_read < FRAME_END));
                // DONE is entered one cycle after the last read, once words_read has caught up
                if (!user_r_open) begin
                    state_next = ST_IDLE;
                end else if (words_read >= FRAME_END) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                eof_int = 1'b1;
                if (!user_r_open) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_accept = io_out_wr_en && !full_int;
    assign rd_accept = user_r_rden && !empty_int;
    // Any edge that lands in IDLE discards buffered words, including leftovers from DONE
    assign flush     = (state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= io_out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            words_read <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            words_read <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (rd_accept && (words_read < FRAME_END)) begin
                words_read <= words_read + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_r_data <= '0;
        end else if (rd_accept) begin
            user_r_data <= mem[rd_ptr];
        end
    end

    assign io_out_full  = full_int;
    assign user_r_empty = empty_int;
    assign user_r_eof   = eof_int;

`ifdef STREAM_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (io_out_wr_en && full_int && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stencil_read_streamer.sv
// Randomized bench for stencil_read_streamer against a queue-based frame model.
// Connects and checks err_cnt when STREAM_ERRCNT_EN is defined.
module tb_stencil_read_streamer;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned FRAME_LEN  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_out_wr_en = 1'b0;
    logic [31:0] io_out_data = '0;
    logic        io_out_full;
    logic        user_r_rden = 1'b0;
    logic        user_r_empty;
    logic [31:0] user_r_data;
    logic        user_r_eof;
    logic        user_r_open = 1'b0;
`ifdef STREAM_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: mode 0 = closed, 1 = frame in progress, 2 = frame delivered
    int unsigned m_mode = 0;
    logic [31:0] m_q[$];
    int unsigned m_reads = 0;
    logic [31:0] m_data = '0;
    int unsigned m_err = 0;

    stencil_read_streamer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .FRAME_LEN  (FRAME_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_out_wr_en (io_out_wr_en),
        .io_out_data  (io_out_data),
        .io_out_full  (io_out_full),
        .user_r_rden  (user_r_rden),
        .user_r_empty (user_r_empty),
        .user_r_data  (user_r_data),
        .user_r_eof   (user_r_eof),
        .user_r_open  (user_r_open)
`ifdef STREAM_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return (m_mode != 1) || (m_q.size() == DEPTH);
    endfunction

    function automatic bit m_empty();
        return !((m_mode == 1) && (m_q.size() > 0) && (m_reads < FRAME_LEN));
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_q.delete();
        m_reads = 0;
        m_data  = '0;
        m_err   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".full"},  {31'd0, io_out_full},  {31'd0, m_full()});
        check({tag, ".empty"}, {31'd0, user_r_empty}, {31'd0, m_empty()});
        check({tag, ".eof"},   {31'd0, user_r_eof},   {31'd0, (m_mode == 2)});
        check({tag, ".data"},  user_r_data, m_data);
`ifdef STREAM_ERRCNT_EN
        check({tag, ".err"},   {16'd0, err_cnt}, m_err);
`endif
    endtask

    // One clock: drive inputs (called just after a falling edge), advance model, check at next falling edge
    task automatic cycle(input bit open, input bit wr, input logic [31:0] data, input bit rd, input string tag);
        bit full_now, empty_now, wr_ok, rd_ok;
        int unsigned reads_before;
        user_r_open  = open;
        io_out_wr_en = wr;
        io_out_data  = data;
        user_r_rden  = rd;
        full_now     = m_full();
        empty_now    = m_empty();
        wr_ok        = wr && !full_now;
        rd_ok        = rd && !empty_now;
        reads_before = m_reads;
        if (wr && full_now && m_err < 16'hFFFF) m_err++;
        if (rd_ok) begin
            m_data = m_q.pop_front();
            m_reads++;
        end
        if (wr_ok) m_q.push_back(data);
        if (!open) begin
            m_mode  = 0;
            m_q.delete();
            m_reads = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && reads_before >= FRAME_LEN) begin
            m_mode = 2;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".full"},  {31'd0, io_out_full},  32'd1);
        check({tag, ".empty"}, {31'd0, user_r_empty}, 32'd1);
        check({tag, ".eof"},   {31'd0, user_r_eof},   32'd0);
        check({tag, ".data"},  user_r_data, 32'd0);
`ifdef STREAM_ERRCNT_EN
        check({tag, ".err"},   {16'd0, err_cnt}, 32'd0);
`endif
        user_r_open  = 1'b0;
        io_out_wr_en = 1'b0;
        user_r_rden  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned guard;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");

        // Fill-then-drain ordering and frame end
        cycle(1, 0, '0, 0, "open");
        cycle(1, 1, 32'h11, 0, "w11");
        cycle(1, 1, 32'h22, 0, "w22");
        cycle(1, 1, 32'h33, 0, "w33");
        cycle(1, 1, 32'h44, 0, "w44");
        cycle(1, 1, 32'h55, 0, "w55_drop");
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1, 0, '0, 1, "rd");
            cycle(1, 0, '0, 0, "rd_gap");
        end
        check("fifo_order_last", user_r_data, 32'h44);

        // Simultaneous read/write at level 2
        cycle(1, 1, 32'hA0, 0, "lvl_a");
        cycle(1, 1, 32'hA1, 0, "lvl_b");
        for (int unsigned i = 0; i < 10; i++) begin
            cycle(1, 1, 32'hB0 + i, 1, "rw");
        end
        check("rw_level", m_q.size(), 32'd2);

        // Finish the frame, then poke writes/reads in DONE
        guard = 0;
        while (m_mode != 2 && guard < 100) begin
            cycle(1, 1, $urandom, 1, "finish");
            guard++;
        end
        check("eof_reached", {31'd0, user_r_eof}, 32'd1);
        cycle(1, 1, 32'hAA, 1, "done_wr");
        cycle(0, 0, '0, 0, "close");
        cycle(1, 0, '0, 0, "reopen");
        check("reopen_eof", {31'd0, user_r_eof}, 32'd0);

        // Close mid-frame with words buffered, reopen, stale data must not reappear
        cycle(1, 1, 32'hC1, 0, "mid_a");
        cycle(1, 1, 32'hC2, 0, "mid_b");
        cycle(1, 1, 32'hC3, 0, "mid_c");
        cycle(0, 0, '0, 0, "mid_close");
        cycle(1, 0, '0, 0, "mid_reopen");
        cycle(1, 1, 32'hD1, 0, "fresh_w");
        cycle(1, 0, '0, 1, "fresh_r");
        check("fresh_word", user_r_data, 32'hD1);

        // Async reset mid-read, then rden while empty
        cycle(1, 1, 32'hE1, 0, "pre_rst");
        user_r_rden = 1'b1;
        async_reset("async_rst");
        cycle(0, 0, '0, 1, "rd_empty");
        check("rd_empty_data", user_r_data, 32'd0);

        // Randomized traffic with occasional closes and one reset
        for (int unsigned i = 0; i < 800; i++) begin
            if (i == 400) async_reset("rand_rst");
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), $urandom,
                  ($urandom_range(0, 9) < 6), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
